// File: rtl/heq_pkg.sv
// Shared widths, scratch-memory base addresses and FSM encoding for the
// histogram-equalization LUT builder.
package heq_pkg;

    localparam int BIN_W       = 32;
    localparam int LUT_W       = 8;
    localparam int WORD_W      = 128;
    localparam int BINS_PER_RD = 4;
    localparam int BINS_PER_WR = 16;

    localparam logic [15:0] CDF_BASE_ADDR_DEF = 16'd64;
    localparam logic [15:0] LUT_BASE_ADDR_DEF = 16'd128;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETUP,
        S_RD_REQ,
        S_RD_WAIT,
        S_LOAD,
        S_DIV_START,
        S_DIV_WAIT,
        S_WRITE,
        S_DONE
    } state_e;

endpackage

// File: rtl/heq_lut_gen_if.sv
// Control, scratch-memory read and LUT write-back signals of the LUT builder.
interface heq_lut_gen_if;
    import heq_pkg::*;

    logic              start;
    logic [BIN_W-1:0]  cdf_min;
    logic [BIN_W-1:0]  total_pixels;
    logic [WORD_W-1:0] mem_rdata;
    logic [15:0]       read_addr;
    logic              we;
    logic [15:0]       write_addr;
    logic [WORD_W-1:0] write_data;
    logic              busy;
    logic              done;
    logic              degenerate;

    modport slave (
        input  start, cdf_min, total_pixels, mem_rdata,
        output read_addr, we, write_addr, write_data, busy, done, degenerate
    );

    modport master (
        output start, cdf_min, total_pixels, mem_rdata,
        input  read_addr, we, write_addr, write_data, busy, done, degenerate
    );

endinterface

// File: rtl/heq_seq_divider.sv
// Restoring divider, one quotient bit per cycle; o_done pulses DIVIDEND_W cycles
// after the i_start cycle. i_start while busy is ignored.
module heq_seq_divider #(
    parameter int DIVIDEND_W = 40,
    parameter int DIVISOR_W  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic [DIVIDEND_W-1:0] i_dividend,
    input  logic [DIVISOR_W-1:0]  i_divisor,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DIVIDEND_W-1:0] o_quotient
);
    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    logic                  r_busy;
    logic                  r_done;
    logic [DIVIDEND_W-1:0] r_quo;
    logic [DIVISOR_W-1:0]  r_rem;
    logic [DIVISOR_W-1:0]  r_dvs;
    logic [CNT_W-1:0]      r_cnt;

    logic [DIVISOR_W:0]    w_trial;
    logic                  w_ge;
    logic [DIVISOR_W-1:0]  w_diff;

    // Remainder stays below the divisor, so only the trial value needs the extra bit.
    assign w_trial = {r_rem, r_quo[DIVIDEND_W-1]};
    assign w_ge    = (w_trial >= {1'b0, r_dvs});
    assign w_diff  = w_trial[DIVISOR_W-1:0] - r_dvs;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_start && !r_busy) begin
                r_busy <= 1'b1;
                r_quo  <= i_dividend;
                r_rem  <= '0;
                r_dvs  <= i_divisor;
                r_cnt  <= CNT_W'(DIVIDEND_W);
            end else if (r_busy) begin
                r_quo <= {r_quo[DIVIDEND_W-2:0], w_ge};
                r_rem <= w_ge ? w_diff : w_trial[DIVISOR_W-1:0];
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_quotient = r_quo;

endmodule

// File: rtl/heq_lut_gen.sv
// Builds the equalization LUT from the CDF in scratch memory, ~41 cycles per bin;
// no backpressure: reads are fixed-latency and each LUT word is a single write pulse.
module heq_lut_gen
    import heq_pkg::*;
#(
    parameter logic [15:0] CDF_BASE_ADDR = CDF_BASE_ADDR_DEF,
    parameter logic [15:0] LUT_BASE_ADDR = LUT_BASE_ADDR_DEF,
    parameter int          NUM_BINS      = 256,
    parameter int          DIVIDEND_W    = 40
) (
    input  logic         clk,
    input  logic         reset,
    heq_lut_gen_if.slave bus
);
    localparam int                LANE_W       = $clog2(BINS_PER_RD);
    localparam logic [15:0]       LAST_WR_ADDR = LUT_BASE_ADDR + 16'(NUM_BINS / BINS_PER_WR - 1);
    localparam logic [LANE_W-1:0] LAST_LANE    = LANE_W'(BINS_PER_RD - 1);
    localparam logic [3:0]        LAST_IN_WORD = 4'(BINS_PER_WR - 1);

    state_e              r_state;
    state_e              w_state_nxt;
    state_e              w_after_bin;

    logic [BIN_W-1:0]    r_cdf_min;
    logic [BIN_W-1:0]    r_total;
    logic [BIN_W-1:0]    r_denom;
    logic                r_degen;
    logic [15:0]         r_rd_addr;
    logic [15:0]         r_wr_addr;
    logic [WORD_W-1:0]   r_wr_data;
    logic [BIN_W-1:0]    r_lane [BINS_PER_RD];
    logic [LANE_W-1:0]   r_lane_idx;
    logic [3:0]          r_word_pos;

    logic [BIN_W-1:0]      w_cdf;
    logic [BIN_W-1:0]      w_num;
    logic [DIVIDEND_W-1:0] w_dividend;
    logic [DIVIDEND_W-1:0] w_quotient;
    logic                  w_div_start;
    logic                  w_div_busy;
    logic                  w_div_done;
    logic                  w_store;
    logic [LUT_W-1:0]      w_byte;

    // Bins before the first non-zero bin clamp to a zero numerator.
    assign w_cdf      = r_lane[r_lane_idx];
    assign w_num      = (w_cdf >= r_cdf_min) ? (w_cdf - r_cdf_min) : '0;
    assign w_dividend = DIVIDEND_W'(w_num) * DIVIDEND_W'(255) + DIVIDEND_W'(r_denom >> 1);

    assign w_div_start = (r_state == S_DIV_START) && !r_degen && !w_div_busy;
    assign w_store     = ((r_state == S_DIV_START) && r_degen) ||
                         ((r_state == S_DIV_WAIT) && w_div_done);
    assign w_byte      = r_degen                              ? '0    :
                         (w_quotient > DIVIDEND_W'(255))      ? 8'hFF :
                                                                w_quotient[LUT_W-1:0];

    heq_seq_divider #(
        .DIVIDEND_W (DIVIDEND_W),
        .DIVISOR_W  (BIN_W)
    ) u_div (
        .clk        (clk),
        .reset      (reset),
        .i_start    (w_div_start),
        .i_dividend (w_dividend),
        .i_divisor  (r_denom),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quotient (w_quotient)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_after_bin = S_RD_REQ;
        if (r_lane_idx != LAST_LANE)         w_after_bin = S_DIV_START;
        else if (r_word_pos == LAST_IN_WORD) w_after_bin = S_WRITE;

        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (bus.start) w_state_nxt = S_SETUP;
            S_SETUP:     w_state_nxt = S_RD_REQ;
            S_RD_REQ:    w_state_nxt = S_RD_WAIT;
            S_RD_WAIT:   w_state_nxt = S_LOAD;
            S_LOAD:      w_state_nxt = S_DIV_START;
            S_DIV_START: begin
                if (r_degen)         w_state_nxt = w_after_bin;
                else if (!w_div_busy) w_state_nxt = S_DIV_WAIT;
            end
            S_DIV_WAIT:  if (w_div_done) w_state_nxt = w_after_bin;
            S_WRITE:     w_state_nxt = (r_wr_addr == LAST_WR_ADDR) ? S_DONE : S_RD_REQ;
            S_DONE:      w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cdf_min  <= '0;
            r_total    <= '0;
            r_denom    <= '0;
            r_degen    <= 1'b0;
            r_rd_addr  <= CDF_BASE_ADDR;
            r_wr_addr  <= LUT_BASE_ADDR;
            r_wr_data  <= '0;
            r_lane_idx <= '0;
            r_word_pos <= '0;
            for (int i = 0; i < BINS_PER_RD; i++) r_lane[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_cdf_min <= bus.cdf_min;
                        r_total   <= bus.total_pixels;
                        r_degen   <= 1'b0;
                    end
                end
                S_SETUP: begin
                    r_denom    <= r_total - r_cdf_min;
                    r_degen    <= (r_total == r_cdf_min);
                    r_rd_addr  <= CDF_BASE_ADDR;
                    r_wr_addr  <= LUT_BASE_ADDR;
                    r_word_pos <= '0;
                end
                S_LOAD: begin
                    for (int i = 0; i < BINS_PER_RD; i++)
                        r_lane[i] <= bus.mem_rdata[WORD_W-1-BIN_W*i -: BIN_W];
                    r_lane_idx <= '0;
                end
                S_DIV_START, S_DIV_WAIT: begin
                    // Bytes enter at the bottom so bin 0 of the word ends in the top byte.
                    if (w_store) begin
                        r_wr_data  <= {r_wr_data[WORD_W-LUT_W-1:0], w_byte};
                        r_word_pos <= r_word_pos + 4'd1;
                        if (r_lane_idx != LAST_LANE)
                            r_lane_idx <= r_lane_idx + 1'b1;
                        else if (r_word_pos != LAST_IN_WORD)
                            r_rd_addr <= r_rd_addr + 16'd1;
                    end
                end
                S_WRITE: begin
                    if (r_wr_addr != LAST_WR_ADDR) begin
                        r_rd_addr <= r_rd_addr + 16'd1;
                        r_wr_addr <= r_wr_addr + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.read_addr  = r_rd_addr;
    assign bus.write_addr = r_wr_addr;
    assign bus.write_data = r_wr_data;
    assign bus.we         = (r_state == S_WRITE);
    assign bus.busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign bus.done       = (r_state == S_DONE);
    assign bus.degenerate = r_degen;

endmodule

// File: tb/tb_heq_lut_gen.sv
// Directed bench for heq_lut_gen: a scratch-memory model serves the CDF, a behavioural
// LUT model predicts every written word, and literal words pin the model.
module tb_heq_lut_gen;

    localparam logic [15:0] CDF_BASE = 16'd64;
    localparam logic [15:0] LUT_BASE = 16'd128;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    heq_lut_gen_if bus();

    heq_lut_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_pass   = 0;
    int n_tot    = 0;
    int wr_idx   = 0;
    int done_cnt = 0;
    int run_base = 0;

    int           hist    [256];
    logic [127:0] cdf_mem [256];
    logic [127:0] lut_mem [256];
    logic [127:0] exp_w   [16];
    logic         exp_degen;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Scratch memory: registered read port, data valid the cycle after the address.
    always @(posedge clk) bus.mem_rdata <= cdf_mem[bus.read_addr[7:0]];

    // Every LUT write is checked against the model in issue order.
    always @(negedge clk) begin
        int rel;
        if (bus.we) begin
            rel = wr_idx - run_base;
            if (rel < 16) begin
                chk("wr_addr", bus.write_addr, LUT_BASE + 16'(rel));
                chk("wr_data", bus.write_data, exp_w[rel]);
            end else begin
                chk("extra_write", rel, 15);
            end
            lut_mem[bus.write_addr[7:0]] <= bus.write_data;
            wr_idx++;
        end
        if (bus.done) done_cnt++;
    end

    task automatic clear_hist();
        for (int v = 0; v < 256; v++) hist[v] = 0;
    endtask

    // Behavioural model: cumulative sum, then the rounded equalization formula.
    task automatic prep(input int cmin, input int npix);
        logic [31:0]  cdf [256];
        longint       acc, c, num, den, q;
        logic [127:0] w;
        acc = 0;
        for (int v = 0; v < 256; v++) begin
            acc += hist[v];
            cdf[v] = 32'(acc);
        end
        for (int k = 0; k < 64; k++)
            cdf_mem[64 + k] = {cdf[4*k], cdf[4*k+1], cdf[4*k+2], cdf[4*k+3]};
        den       = longint'(npix) - longint'(cmin);
        exp_degen = (den == 0);
        for (int k = 0; k < 16; k++) begin
            w = '0;
            for (int j = 0; j < 16; j++) begin
                c   = longint'(cdf[16*k + j]);
                num = (c >= cmin) ? c - cmin : 0;
                q   = (den == 0) ? 0 : (num * 255 + den / 2) / den;
                if (q > 255) q = 255;
                w[127 - 8*j -: 8] = 8'(q);
            end
            exp_w[k] = w;
        end
    endtask

    task automatic kick(input int cmin, input int npix);
        @(negedge clk);
        bus.start        = 1'b1;
        bus.cdf_min      = 32'(cmin);
        bus.total_pixels = 32'(npix);
        @(negedge clk);
        bus.start        = 1'b0;
        bus.cdf_min      = 32'hFFFF_FFFF;
        bus.total_pixels = 32'd0;
    endtask

    task automatic run_build(input string tag, input int cmin, input int npix, input bit poke);
        bit seen;
        int d0;
        prep(cmin, npix);
        run_base = wr_idx;
        d0       = done_cnt;
        kick(cmin, npix);
        chk({tag, "_busy"}, bus.busy, 1);
        chk({tag, "_degen_clr"}, bus.degenerate, 0);
        seen = 1'b0;
        for (int cyc = 0; cyc < 12000 && !seen; cyc++) begin
            @(negedge clk);
            if (bus.done) begin
                seen      = 1'b1;
                bus.start = poke;
            end else begin
                bus.start = poke && (cyc == 40 || cyc == 4000);
            end
        end
        chk({tag, "_done_in_time"}, seen, 1);
        chk({tag, "_writes"}, wr_idx - run_base, 16);
        chk({tag, "_degenerate"}, bus.degenerate, exp_degen);
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, "_done_pulse"}, bus.done, 0);
        chk({tag, "_idle"}, bus.busy, 0);
        chk({tag, "_done_cnt"}, done_cnt - d0, 1);
    endtask

    initial begin
        bit found;
        bus.start        = 1'b0;
        bus.cdf_min      = '0;
        bus.total_pixels = '0;
        for (int i = 0; i < 256; i++) cdf_mem[i] = '0;

        repeat (3) @(negedge clk);
        chk("rst_read_addr", bus.read_addr, CDF_BASE);
        chk("rst_write_addr", bus.write_addr, LUT_BASE);
        chk("rst_write_data", bus.write_data, 0);
        chk("rst_we", bus.we, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_degenerate", bus.degenerate, 0);
        reset = 1'b0;

        // Uniform histogram: lut(v) = v
        clear_hist();
        for (int v = 0; v < 256; v++) hist[v] = 32400;
        run_build("t1", 32400, 8294400, 1'b0);
        chk("t1_word0", lut_mem[128], 128'h000102030405060708090A0B0C0D0E0F);
        chk("t1_word15", lut_mem[143], 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);

        // Leading empty bins use the clamped numerator
        clear_hist();
        hist[10]  = 1000;
        hist[255] = 1000;
        run_build("t2", 1000, 2000, 1'b0);
        chk("t2_word0", lut_mem[128], 128'h0);
        chk("t2_word15", lut_mem[143], 128'h000000000000000000000000000000FF);

        // Rounding: (255+3)/7 = 36
        clear_hist();
        hist[0] = 1;
        hist[1] = 1;
        hist[2] = 6;
        run_build("t3", 1, 8, 1'b0);
        chk("t3_model_word0", exp_w[0], 128'h0024FFFFFFFFFFFFFFFFFFFFFFFFFFFF);
        chk("t3_word0", lut_mem[128], 128'h0024FFFFFFFFFFFFFFFFFFFFFFFFFFFF);
        chk("t3_word1", lut_mem[129], {128{1'b1}});

        // Degenerate: every pixel in one bin
        clear_hist();
        hist[100] = 5000;
        run_build("t4", 5000, 5000, 1'b0);
        chk("t4_word0", lut_mem[128], 128'h0);
        chk("t4_word15", lut_mem[143], 128'h0);
        repeat (5) @(negedge clk);
        chk("t4_degen_held", bus.degenerate, 1);

        // Start pulses while busy and on the done cycle are ignored
        clear_hist();
        for (int v = 0; v < 256; v++) hist[v] = 32400;
        run_build("t5", 32400, 8294400, 1'b1);
        chk("t5_word0", lut_mem[128], 128'h000102030405060708090A0B0C0D0E0F);
        chk("t5_word7", lut_mem[135], 128'h707172737475767778797A7B7C7D7E7F);

        // Reset during the sixth LUT write aborts the run
        prep(32400, 8294400);
        run_base = wr_idx;
        kick(32400, 8294400);
        found = 1'b0;
        for (int cyc = 0; cyc < 12000 && !found; cyc++) begin
            @(negedge clk);
            if (bus.we && bus.write_addr == LUT_BASE + 16'd5) found = 1'b1;
        end
        chk("abort_reached_word5", found, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_we", bus.we, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_read_addr", bus.read_addr, CDF_BASE);
        chk("abort_write_addr", bus.write_addr, LUT_BASE);
        repeat (300) @(negedge clk);
        chk("abort_no_more_writes", wr_idx - run_base, 6);
        chk("abort_stays_idle", bus.busy, 0);

        clear_hist();
        hist[0] = 7;
        lut_mem[128] = '0;
        clear_hist();
        for (int v = 0; v < 256; v++) hist[v] = 32400;
        run_build("t5r", 32400, 8294400, 1'b0);
        chk("t5r_word0", lut_mem[128], 128'h000102030405060708090A0B0C0D0E0F);
        chk("t5r_word15", lut_mem[143], 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/heq_lut_gen.md
Name: heq_lut_gen

Overview:
Downstream stage of the CDF datapath in the histogram-equalization pipeline. It reads the 256-bin CDF (four 32-bit bins per 128-bit scratch-memory word) and computes the 8-bit equalization mapping lut(v) = round((cdf(v) - cdf_min) * 255 / (total_pixels - cdf_min)). It packs 16 LUT bytes per 128-bit word and writes the LUT back to scratch memory for the pixel-remap stage.

Parameters:
CDF_BASE_ADDR, 16'd64, scratch address of the CDF word holding bins 0..3
LUT_BASE_ADDR, 16'd128, scratch address of the LUT word holding bins 0..15
NUM_BINS, 256, intensity bins; must be a multiple of 16
DIVIDEND_W, 40, width of the rounding dividend and the divider

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that launches a LUT build; ignored while busy=1
cdf_min  in  32  first non-zero CDF value; sampled only on an accepted start
total_pixels  in  32  pixel count N; sampled only on an accepted start
mem_rdata  in  128  scratch read data; valid on the cycle after read_addr is driven
read_addr  out  16  scratch read address, registered
we  out  1  write enable, one-cycle pulse per LUT word
write_addr  out  16  scratch write address, registered
write_data  out  128  packed LUT word; bin 16k+j sits at bits [127-8j -: 8]
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last LUT write
degenerate  out  1  set when denom==0; held until the next accepted start or reset

Behaviour:
- Reset values: read_addr = CDF_BASE_ADDR, write_addr = LUT_BASE_ADDR, write_data = 0, we = 0, busy = 0, done = 0, degenerate = 0, FSM in IDLE.
- Reset mid-run: the block returns to IDLE on the next edge, aborts the divider, and issues no further writes.
- CDF layout: bin 4k+i is mem_rdata[127-32i -: 32] at address CDF_BASE_ADDR+k.
- FSM:
  - IDLE: waits for start.
  - SETUP: latches cdf_min and total_pixels, computes denom = total_pixels - cdf_min, and sets degenerate = (denom == 0).
  - RD_REQ: drives read_addr.
  - RD_WAIT: single wait cycle.
  - LOAD: captures the 128-bit word into 4 lane registers and sets lane = 0.
  - DIV_START → DIV_WAIT: computes one bin.
  - After each bin the byte is stored. If lane < 3, the FSM goes to DIV_START with lane+1. Otherwise, if the bin index mod 16 == 15, it goes to WRITE; else it goes to RD_REQ with read_addr+1.
  - WRITE: we = 1 for exactly one cycle at write_addr. The next state is DONE if this is the last word; otherwise write_addr+1 and RD_REQ.
  - DONE: done = 1 for one cycle, busy drops, FSM returns to IDLE.
- Arithmetic per bin:
  - num = (cdf >= cdf_min) ? cdf - cdf_min : 0 (clamps bins that precede the first non-zero bin).
  - dividend = num*255 + (denom>>1), DIVIDEND_W bits, no overflow.
  - q = dividend / denom, clamped to 255, and the low 8 bits are stored.
  - If denom == 0, the divider is bypassed and the byte is 0.
- Divider: restoring, 1 quotient bit per cycle. done is asserted DIVIDEND_W cycles after the start cycle. A start issued while the divider is running is illegal and the FSM never issues one.
- Totals: 64 reads and NUM_BINS/16 = 16 writes at LUT_BASE_ADDR..LUT_BASE_ADDR+15, in ascending order. A run completes in under 12000 cycles.
- start while busy: no effect. start on the DONE cycle: ignored.

Decomposition:
- Shared package heq_pkg holds:
  - the constants BIN_W=32, LUT_W=8, WORD_W=128, BINS_PER_RD=4, BINS_PER_WR=16
  - the base-address defaults
  - the FSM state enum
- One sub-module: heq_seq_divider, which provides start/busy/done, a DIVIDEND_W-bit dividend, a 32-bit divisor, and a DIVIDEND_W-bit quotient.

Test Plan:
1. Uniform histogram, 32400 pixels per bin: cdf(v) = 32400(v+1), cdf_min = 32400, N = 8294400 -> lut(v) = v; 16 writes at addresses 128..143; first word 0x000102030405060708090A0B0C0D0E0F; degenerate = 0.
2. Bins 0..9 zero, bin 10 = 1000, bin 255 = 1000, N = 2000, cdf_min = 1000 -> lut[0..254] = 0 (bins 0..9 use the clamped numerator), lut[255] = 255; last word 0x00..00FF.
3. Rounding: bin0 = 1, bin1 = 1, bin2 = 6, N = 8, cdf_min = 1, denom = 7 -> lut0 = 0, lut1 = (255+3)/7 = 36, lut2..255 = 255; first word 0x0024FFFF..FF.
4. All pixels in bin 100: N = 5000, cdf_min = 5000 -> degenerate = 1, 16 writes of all-zero data, done pulses once.
5. start pulsed again mid-run -> no restart and output identical to test 1. reset asserted during the 6th write word -> we = 0 and busy = 0 from the next cycle; a fresh start then reproduces the full test 1 output.
